// File: rtl/output_hold_limiter_pkg.sv
// Shared types and helpers for the output hold limiter: per-bit FSM state
// encoding and a width helper for sizing the hold counter from HOLD.
package output_hold_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } hold_state_e;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input longint unsigned value);
        int unsigned bits;
        bits = 0;
        while ((64'd1 << bits) < value) begin
            bits++;
        end
        return bits;
    endfunction

    // Smallest counter width W with 2**W > hold (at least 1 bit).
    function automatic int unsigned hold_width(input int unsigned hold);
        int unsigned bits;
        bits = clog2(64'(hold) + 64'd1);
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/output_hold_limiter_if.sv
// Bundle of the rate-limited output bus: requested levels in, held levels and
// deferred-change flags out.
interface output_hold_limiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] pending;

    modport master (
        output data_in,
        input  data_out,
        input  pending
    );

    modport slave (
        input  data_in,
        output data_out,
        output pending
    );
endinterface

// File: rtl/output_hold_limiter_bit.sv
// One output bit: forwards din to dout but keeps dout stable for at least
// HOLD cycles after every change; the value sampled at hold expiry wins.
module output_hold_bit
    import output_hold_pkg::*;
#(
    parameter int unsigned HOLD       = 50000,
    parameter int unsigned HOLD_WIDTH = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic pend
);

    localparam logic [HOLD_WIDTH-1:0] CNT_LAST = HOLD_WIDTH'(HOLD - 1);
    localparam logic [HOLD_WIDTH-1:0] CNT_ONE  = HOLD_WIDTH'(1);

    hold_state_e           state_q, state_d;
    logic [HOLD_WIDTH-1:0] cnt_q,   cnt_d;
    logic                  dout_q,  dout_d;
    logic                  pend_q,  pend_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        pend_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (din != dout_q) begin
                    dout_d  = din;
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    // Expiry: apply a still-differing request back-to-back,
                    // otherwise the hold is satisfied and we go idle.
                    cnt_d = '0;
                    if (din != dout_q) begin
                        dout_d = din;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d  = cnt_q + CNT_ONE;
                    pend_d = (din != dout_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            pend_q  <= pend_d;
        end
    end

    assign dout = dout_q;
    assign pend = pend_q;

endmodule

// File: rtl/output_hold_limiter.sv
// Per-bit minimum-hold enforcer for FPGA outputs: WIDTH independent copies
// of output_hold_bit, no shared logic.
module output_hold_limiter
    import output_hold_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned HOLD       = 50000,
    parameter int unsigned HOLD_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] pending
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        output_hold_bit #(
            .HOLD       (HOLD),
            .HOLD_WIDTH (HOLD_WIDTH)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (data_in[g]),
            .dout    (data_out[g]),
            .pend    (pending[g])
        );
    end

endmodule

// File: doc/output_hold_limiter.md
Name: output_hold_limiter

Overview:
- Transmit-side counterpart to the input debouncer: per-bit minimum-hold enforcer for outputs leaving the FPGA (LEDs, relay/solenoid drives, external enables).
- Internal logic drives synchronous, possibly fast-toggling levels into `data_in`.
- The block forwards each bit to `data_out` but never lets an output change more than once every `HOLD` clock cycles. A changed request arriving during a hold is deferred and applied when the hold expires (last value wins).
- Sits between control logic and output pads. It is the mirror of the debouncer, which cleans incoming levels.

Parameters:
- `WIDTH`, 8, number of independent output bits.
- `HOLD`, 50000, minimum cycles `data_out[i]` stays stable after any change; legal range 1 .. 2^`HOLD_WIDTH`-1.
- `HOLD_WIDTH`, 16, hold counter width; must satisfy 2^`HOLD_WIDTH` > `HOLD`.

Ports:
- `clk`, input, 1, single system clock; all logic on rising edge.
- `reset_n`, input, 1, asynchronous active-low reset.
- `data_in`, input, `WIDTH`, requested output levels; synchronous to `clk`, no synchronizer inside.
- `data_out`, output, `WIDTH`, registered rate-limited levels to pads.
- `pending`, output, `WIDTH`, registered; 1 = a requested change for that bit is deferred by an active hold.

Behaviour:
- Per-bit FSM, all bits fully independent; states `IDLE` (hold satisfied) and `HOLD`; per-bit counter `cnt[HOLD_WIDTH-1:0]`.
- Reset (`reset_n`=0, asynchronous, effective immediately, including mid-hold):
  - `data_out`=0, `pending`=0, state=`IDLE`, `cnt`=0.
  - Deferred requests are discarded.
- `IDLE`:
  - If `data_in[i]` != `data_out[i]` at a rising edge, that edge sets `data_out[i]`<=`data_in[i]`, `cnt`<=0 and state<=`HOLD`. Latency is 1 cycle.
  - Otherwise no change.
- `HOLD`:
  - While `cnt` < `HOLD`-1: `cnt` increments each edge and `data_out[i]` is frozen.
  - At the edge where `cnt`==`HOLD`-1 (hold expiry):
    - If `data_in[i]` != `data_out[i]`: `data_out[i]`<=`data_in[i]`, `cnt`<=0, stay in `HOLD` (back-to-back change, no idle gap).
    - Otherwise: state<=`IDLE`, `cnt`<=0.
- Guarantee: `data_out[i]` is stable for at least `HOLD` consecutive cycles after every transition. Transitions are exactly `HOLD` cycles apart when `data_in` is held different.
- Only the value sampled at the expiry edge matters. A glitch that returns to the current `data_out` before expiry causes no output change.
- `pending[i]` is registered. At each edge it is set to 1 if, after that edge, state is `HOLD` and the sampled `data_in[i]` != post-edge `data_out[i]`; otherwise 0.
  - It is 0 in the cycle immediately after an applied change unless `data_in` already differs again.
  - It clears on the edge that applies the deferred value or the edge where `data_in` returns to `data_out`.
- `HOLD`=1: `cnt`==0==`HOLD`-1 on every cycle in `HOLD`, so an output may change every cycle; the block is equivalent to a 1-cycle register.
- Counter never wraps: it is cleared on every change and on expiry, and its maximum value is `HOLD`-1.
- A simultaneous change request and expiry on the same edge is handled by the expiry rule above.
- Changes on different bits in the same cycle are each handled independently.
- No initial blocks are relied upon; reset defines all state.

Decomposition:
- Shared header/package `output_hold_pkg`:
  - state encoding localparams `ST_IDLE`=1'b0, `ST_HOLD`=1'b1;
  - a `clog2`-style helper so integrators can derive `HOLD_WIDTH` from `HOLD`.
- One sub-module, `output_hold_bit` (parameters `HOLD`, `HOLD_WIDTH`; ports `clk`, `reset_n`, `din`, `dout`, `pend`), holds the FSM and counter for one bit.
- The top instantiates `WIDTH` copies in a generate loop; the top has no other logic.

Test Plan:
- Reset, `WIDTH`=4, `HOLD`=4: assert `reset_n`=0 with `data_in`=4'hF -> `data_out`=0 and `pending`=0 throughout. Release with `data_in`=4'hF -> `data_out`=4'hF exactly 1 cycle after the first edge.
- Deferred change: bit0 rises at edge E0, `data_in[0]`->0 at E1 -> `pending[0]`=1 from E2. `data_out[0]` is 1 for edges E0..E3 and falls at E4. `pending[0]`=0 after E4.
- Glitch suppression: `data_out[0]`=1 in `HOLD`; `data_in[0]` pulses 0 for 2 cycles, then returns to 1 before expiry -> `data_out[0]` never falls; `pending[0]` is 1 during the pulse only; state goes back to `IDLE`.
- Fast toggle: `data_in[0]` toggles every cycle for 20 cycles -> `data_out[0]` changes at most every 4 cycles; every output interval is ≥4 cycles.
- Independence/simultaneous: bits 0 and 2 change on the same edge and bit1 changes 2 cycles later -> each bit follows its own 1-cycle latency and 4-cycle hold with no interaction.
- Reset mid-hold: `reset_n` dropped asynchronously while bit0 has `pending`=1 -> `data_out`, `pending` and counters clear immediately without waiting for a clock edge. After release with `data_in`=0 there is no stale deferred change.
